// File: rtl/fp_align_stage2.sv
// fp_align_stage2: orders operands, aligns the smaller significand with guard/round/sticky,
// flags NaN/Inf, and registers the bundle behind a 2-entry skid buffer.
module fp_align_stage2 #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8,
    parameter int GRS_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     A_sign,
    input  logic                     B_sign_eff,
    input  logic [EXP_W-1:0]         A_exp,
    input  logic [EXP_W-1:0]         B_exp,
    input  logic [MAN_W-1:0]         A_man,
    input  logic [MAN_W-1:0]         B_man,
    input  logic [EXP_W-1:0]         exp_diff,
    input  logic                     A_bigger,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     big_sign,
    output logic                     eff_sub,
    output logic [EXP_W-1:0]         res_exp,
    output logic [MAN_W+GRS_W-1:0]   big_man,
    output logic [MAN_W+GRS_W-1:0]   small_man,
    output logic                     swapped,
    output logic                     is_nan,
    output logic                     is_inf
);
    localparam int FW = MAN_W + GRS_W;

    typedef struct packed {
        logic             big_sign;
        logic             eff_sub;
        logic [EXP_W-1:0] res_exp;
        logic [FW-1:0]    big_man;
        logic [FW-1:0]    small_man;
        logic             swapped;
        logic             is_nan;
        logic             is_inf;
    } bundle_t;

    logic             sel_a, a_nan, b_nan, a_inf, b_inf, one_den, lost;
    logic [EXP_W-1:0] shamt;
    logic [MAN_W-1:0] sm;
    logic [FW-1:0]    ext, mask;
    bundle_t          in_b;

    always_comb begin
        a_nan  = (&A_exp) && (|A_man[MAN_W-2:0]);
        b_nan  = (&B_exp) && (|B_man[MAN_W-2:0]);
        a_inf  = (&A_exp) && !(|A_man[MAN_W-2:0]);
        b_inf  = (&B_exp) && !(|B_man[MAN_W-2:0]);
        sel_a  = (A_exp != B_exp) ? A_bigger : (A_man >= B_man);
        sm     = sel_a ? B_man : A_man;
        // a denormal's effective exponent is 1, so one shift fewer is needed
        one_den = (A_exp == '0) ^ (B_exp == '0);
        shamt  = exp_diff - EXP_W'(one_den);
        ext    = {sm, {GRS_W{1'b0}}};
        mask   = ~({FW{1'b1}} << shamt);
        lost   = |(ext & mask);
        in_b.big_sign  = sel_a ? A_sign : B_sign_eff;
        in_b.eff_sub   = A_sign ^ B_sign_eff;
        in_b.res_exp   = sel_a ? A_exp : B_exp;
        in_b.big_man   = {(sel_a ? A_man : B_man), {GRS_W{1'b0}}};
        in_b.small_man = (shamt >= EXP_W'(FW)) ? {{(FW-1){1'b0}}, |sm}
                                               : (ext >> shamt) | {{(FW-1){1'b0}}, lost};
        in_b.swapped   = !sel_a;
        in_b.is_nan    = a_nan || b_nan || (a_inf && b_inf && (A_sign ^ B_sign_eff));
        in_b.is_inf    = (a_inf || b_inf) && !in_b.is_nan;
    end

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q;
    logic    acc, drain;

    always_comb begin
        acc      = in_valid && in_ready_q;
        drain    = main_v_q && out_ready;
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (!main_v_q || drain) begin
            main_v_d = skid_v_q || acc;
            main_d   = skid_v_q ? skid_q : (acc ? in_b : main_q);
            skid_v_d = skid_v_q && acc;
            skid_d   = (skid_v_q && acc) ? in_b : skid_q;
        end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d   = in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign big_sign  = main_q.big_sign;
    assign eff_sub   = main_q.eff_sub;
    assign res_exp   = main_q.res_exp;
    assign big_man   = main_q.big_man;
    assign small_man = main_q.small_man;
    assign swapped   = main_q.swapped;
    assign is_nan    = main_q.is_nan;
    assign is_inf    = main_q.is_inf;
endmodule
